draw_arbiter: RTL and testbench

Round-robin arbiter that shares the single VGA framebuffer write port between several pixel-drawing engines (ball, paddle, brick and erase drawers). Each engine requests the port, receives an exclusive grant for a whole shape, and signals completion; the arbiter forwards the granted engine's pixel stream to the VGA adapter through one register stage. It sits between the draw engines and the `vga_adapter` instance at the top level.

---
 rtl/draw_arbiter_if.sv | 29 ++
 rtl/draw_arbiter.sv | 112 +++++++++++
 tb/tb_draw_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/draw_arbiter_if.sv
// rtl/draw_arbiter_if.sv - draw engine / VGA write port bundle for draw_arbiter
// master is the engine-and-VGA side, slave is the arbiter.
interface draw_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    done;
   logic [NREQ-1:0]    wren_in;
   logic [NREQ*10-1:0] x_in;
   logic [NREQ*10-1:0] y_in;
   logic [NREQ*3-1:0]  colour_in;
   logic [NREQ-1:0]    grant;
   logic               busy;
   logic               writeEn;
   logic [9:0]         x_out;
   logic [9:0]         y_out;
   logic [2:0]         colour_out;
   logic               timeout;

   modport master (
      output req, done, wren_in, x_in, y_in, colour_in,
      input  grant, busy, writeEn, x_out, y_out, colour_out, timeout
   );

   modport slave (
      input  req, done, wren_in, x_in, y_in, colour_in,
      output grant, busy, writeEn, x_out, y_out, colour_out, timeout
   );
endinterface

// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - round-robin owner of the VGA framebuffer write port
// Optional grant watchdog enabled by DRAW_ARB_TIMEOUT_EN.
module draw_arbiter #(
   parameter int NREQ      = 4,
   parameter int MAX_GRANT = 1023
) (
   input logic           clk,
   input logic           reset,
   draw_arbiter_if.slave bus
);
   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] nxt;
   logic [PW-1:0] idx;
   logic          any_req;
   logic [9:0]    xs   [NREQ];
   logic [9:0]    ys   [NREQ];
   logic [2:0]    cols [NREQ];

   // Scan from farthest to nearest so the closest requester after ptr wins.
   always_comb begin
      any_req = 1'b0;
      nxt     = ptr;
      idx     = ptr;
      for (int i = NREQ; i >= 1; i--) begin
         idx = PW'((int'(ptr) + i) % NREQ);
         if (bus.req[idx]) begin
            any_req = 1'b1;
            nxt     = idx;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         xs[i]   = bus.x_in[10*i +: 10];
         ys[i]   = bus.y_in[10*i +: 10];
         cols[i] = bus.colour_in[3*i +: 3];
      end
   end

`ifdef DRAW_ARB_TIMEOUT_EN
   logic [9:0] cnt;
`else
   assign bus.timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         ptr            <= PW'(NREQ - 1);
         bus.grant      <= '0;
         bus.busy       <= 1'b0;
         bus.writeEn    <= 1'b0;
         bus.x_out      <= '0;
         bus.y_out      <= '0;
         bus.colour_out <= '0;
`ifdef DRAW_ARB_TIMEOUT_EN
         bus.timeout    <= 1'b0;
         cnt            <= '0;
`endif
      end else begin
         bus.writeEn <= (state == GRANT) && bus.wren_in[ptr];
         if (state == GRANT) begin
            bus.x_out      <= xs[ptr];
            bus.y_out      <= ys[ptr];
            bus.colour_out <= cols[ptr];
         end
`ifdef DRAW_ARB_TIMEOUT_EN
         bus.timeout <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (any_req) begin
                  state     <= GRANT;
                  ptr       <= nxt;
                  bus.grant <= NREQ'(1) << nxt;
                  bus.busy  <= 1'b1;
`ifdef DRAW_ARB_TIMEOUT_EN
                  cnt       <= '0;
`endif
               end
            end
            GRANT: begin
               if (bus.done[ptr]) begin
                  state     <= RELEASE;
                  bus.grant <= '0;
               end
`ifdef DRAW_ARB_TIMEOUT_EN
               // ptr already names the offender, so the next scan starts past it.
               else if (cnt == 10'(MAX_GRANT - 1)) begin
                  state       <= RELEASE;
                  bus.grant   <= '0;
                  bus.timeout <= 1'b1;
               end else begin
                  cnt <= cnt + 10'd1;
               end
`endif
            end
            RELEASE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_draw_arbiter.sv
// tb/tb_draw_arbiter.sv - scoreboard bench for draw_arbiter (NREQ=4)
module tb_draw_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   fails  = 0;

   draw_arbiter_if #(.NREQ(4)) bus ();
   draw_arbiter #(.NREQ(4), .MAX_GRANT(20)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   logic [3:0]  exp_grant_q [$];
   logic [22:0] exp_pix_q   [$];
   logic [3:0]  prev_grant = 4'b0000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every new grant and every write strobe is matched against the scoreboard.
   always @(negedge clk) begin
      if (bus.grant !== prev_grant && bus.grant != 4'b0000) begin
         if (exp_grant_q.size() == 0) chk("unexpected_grant", 32'(bus.grant), 32'hFFFF);
         else chk("grant", 32'(bus.grant), 32'(exp_grant_q.pop_front()));
      end
      prev_grant = bus.grant;
      if (bus.writeEn === 1'b1) begin
         if (exp_pix_q.size() == 0) chk("unexpected_writeEn", 32'({bus.x_out, bus.y_out, bus.colour_out}), 32'hFFFFFF);
         else chk("pixel", 32'({bus.x_out, bus.y_out, bus.colour_out}), 32'(exp_pix_q.pop_front()));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input int e, input logic [9:0] x, input logic [9:0] y, input logic [2:0] c);
      bus.x_in[10*e +: 10]    = x;
      bus.y_in[10*e +: 10]    = y;
      bus.colour_in[3*e +: 3] = c;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      reset = 1'b1;
      bus.req = '0; bus.done = '0; bus.wren_in = '0;
      bus.x_in = '0; bus.y_in = '0; bus.colour_in = '0;
      tick(2);
      chk("reset_grant", 32'(bus.grant), 0);
      chk("reset_busy", 32'(bus.busy), 0);
      chk("reset_writeEn", 32'(bus.writeEn), 0);
      chk("reset_x_out", 32'(bus.x_out), 0);
      chk("reset_timeout", 32'(bus.timeout), 0);

      // Round robin with all four requesting.
      bus.req = 4'b1111;
      exp_grant_q.push_back(4'b0001); exp_grant_q.push_back(4'b0010);
      exp_grant_q.push_back(4'b0100); exp_grant_q.push_back(4'b1000);
      exp_grant_q.push_back(4'b0001);
      reset = 1'b0;
      tick(1);
      chk("first_grant_direct", 32'(bus.grant), 32'h1);
      for (int i = 0; i < 5; i++) begin
         bus.done = 4'(1 << (i % 4));
         if (i == 4) bus.req = 4'b0000;
         tick(1);
         bus.done = '0;
         chk("release_grant", 32'(bus.grant), 0);
         chk("release_busy", 32'(bus.busy), 1);
         tick(1);
         chk("idle_busy", 32'(bus.busy), 0);
         tick(1);
      end
      chk("rr_grant_queue_empty", 32'(exp_grant_q.size()), 0);

      // Engine 2 pixel stream, engine 1 toggling wren without a grant.
      bus.req = 4'b0100;
      exp_grant_q.push_back(4'b0100);
      tick(1);
      bus.req = 4'b0000;
      set_pix(1, 10'd999, 10'd999, 3'b001);
      begin
         int p = 0;
         for (int k = 0; k < 11; k++) begin
            bus.wren_in[1] = (k % 2 == 0);
            if (k == 4 || k == 8) bus.wren_in[2] = 1'b0;
            else begin
               bus.wren_in[2] = 1'b1;
               set_pix(2, 10'(100 + p), 10'd50, 3'b111);
               exp_pix_q.push_back({10'(100 + p), 10'd50, 3'b111});
               p++;
            end
            tick(1);
         end
      end
      bus.wren_in = '0;
      bus.done = 4'b0100;
      tick(1);
      bus.done = '0;
      tick(2);
      chk("x_out_hold", 32'(bus.x_out), 108);
      chk("colour_out_hold", 32'(bus.colour_out), 7);
      chk("pixel_queue_empty", 32'(exp_pix_q.size()), 0);

      // Foreign done is ignored.
      bus.req = 4'b1000;
      exp_grant_q.push_back(4'b1000);
      tick(1);
      bus.done = 4'b0010;
      tick(1);
      bus.done = '0;
      chk("foreign_done_grant", 32'(bus.grant), 32'h8);
      chk("foreign_done_busy", 32'(bus.busy), 1);
      tick(1);
      chk("foreign_done_grant2", 32'(bus.grant), 32'h8);
      bus.done = 4'b1000; bus.req = '0;
      tick(1);
      bus.done = '0;
      tick(2);

      // Reset in the 5th grant cycle.
      bus.req = 4'b0001;
      exp_grant_q.push_back(4'b0001);
      tick(1);
      bus.wren_in = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         set_pix(0, 10'(200 + k), 10'd7, 3'b010);
         exp_pix_q.push_back({10'(200 + k), 10'd7, 3'b010});
         tick(1);
      end
      reset = 1'b1;
      bus.req = 4'b0110;
      tick(1);
      chk("midreset_grant", 32'(bus.grant), 0);
      chk("midreset_writeEn", 32'(bus.writeEn), 0);
      chk("midreset_busy", 32'(bus.busy), 0);
      bus.wren_in = '0;
      reset = 1'b0;
      exp_grant_q.push_back(4'b0010);
      tick(1);
      bus.done = 4'b0010; bus.req = '0;
      tick(1);
      bus.done = '0;
      tick(2);

`ifdef DRAW_ARB_TIMEOUT_EN
      bus.req = 4'b0011;
      exp_grant_q.push_back(4'b0001);
      tick(1);
      bus.req = 4'b0010;
      tick(19);
      chk("timeout_early", 32'(bus.timeout), 0);
      tick(1);
      chk("timeout_pulse", 32'(bus.timeout), 1);
      chk("timeout_grant", 32'(bus.grant), 0);
      exp_grant_q.push_back(4'b0010);
      tick(1);
      chk("timeout_one_cycle", 32'(bus.timeout), 0);
      tick(1);
      bus.req = '0;
      tick(19);
      bus.done = 4'b0010;
      tick(1);
      bus.done = '0;
      chk("coincident_timeout", 32'(bus.timeout), 0);
      chk("coincident_grant", 32'(bus.grant), 0);
      tick(2);
`else
      chk("timeout_tied", 32'(bus.timeout), 0);
`endif

      tick(2);
      chk("grant_queue_empty", 32'(exp_grant_q.size()), 0);
      chk("pix_queue_empty_end", 32'(exp_pix_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
